store_write_buffer: RTL

//  Write-through store buffer between the D-cache/MEM stage and the 4-cycle main memory.
//  It captures committed stores and drains them in FIFO order to main memory through a
//  req/grant handshake with the cache arbiter, so the pipeline need not stall per store.
//  It forwards buffered store data to loads that hit a pending entry.

---
 rtl/store_write_buffer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/store_write_buffer.sv
// Write-through store buffer: queues committed stores, drains them in FIFO order to
// main memory over a req/grant port, and forwards pending store data to matching loads.
module store_write_buffer #(
   parameter int DEPTH        = 4,
   parameter int WRITE_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     store_valid,
   input  logic [15:0]              store_addr,
   input  logic [15:0]              store_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   input  logic                     load_check,
   input  logic [15:0]              load_addr,
   output logic                     load_hit,
   output logic [15:0]              load_data,
   output logic                     mem_req,
   input  logic                     mem_grant,
   output logic                     mem_wr,
   output logic [15:0]              mem_addr,
   output logic [15:0]              mem_data,
   output logic [1:0]               dbg_state
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int WCNT_W = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WRITE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WRITE = 2'd2
   } state_e;

   // Handshake: mem_req stays high from REQ through the whole WRITE burst; a write burst
   // starts on the cycle after mem_req & mem_grant, and grant is not re-sampled mid-burst.
   state_e              state_q, state_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [15:0]         addr_q [DEPTH];
   logic [15:0]         data_q [DEPTH];

   logic push;
   logic pop;

   // full comes from the registered count, so a push while full is dropped even on a pop.
   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);
   assign count = count_q;
   assign push  = store_valid & ~full;
   assign pop   = (state_q == ST_WRITE) && (wcnt_q == WCNT_LAST);

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (push) begin
            addr_q[wr_ptr_q] <= store_addr;
            data_q[wr_ptr_q] <= store_data;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // FSM next state; IDLE looks at the post-push count so a lone store requests at once
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (count_d != '0) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_grant) begin
               state_d = ST_WRITE;
               wcnt_d  = '0;
            end
         end
         ST_WRITE: begin
            if (pop) begin
               wcnt_d  = '0;
               state_d = (count_d != '0) ? ST_REQ : ST_IDLE;
            end else begin
               wcnt_d = wcnt_q + WCNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            wcnt_d  = '0;
         end
      endcase
   end

   // FSM outputs
   always_comb begin
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      dbg_state = state_q;
      case (state_q)
         ST_REQ: begin
            mem_req = 1'b1;
         end
         ST_WRITE: begin
            mem_req = 1'b1;
            mem_wr  = 1'b1;
         end
         default: begin
            mem_req = 1'b0;
            mem_wr  = 1'b0;
         end
      endcase
   end

   assign mem_addr = addr_q[rd_ptr_q];
   assign mem_data = data_q[rd_ptr_q];

   // Walk oldest to youngest so the last match (youngest) is the one that sticks.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx       = '0;
      load_hit  = 1'b0;
      load_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && (addr_q[idx] == load_addr)) begin
            load_hit  = 1'b1;
            load_data = data_q[idx];
         end
      end
      if (!load_check) begin
         load_hit  = 1'b0;
         load_data = '0;
      end
   end

endmodule
